// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared types and limits for the hash engine scheduler
package sha_pkg;

    localparam int MAX_CORES = 16;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        ARM,
        WAIT,
        WRITE
    } state_t;

endpackage

// File: rtl/nonce_batch_scheduler.sv
// rtl/nonce_batch_scheduler.sv - batches nonces across hash engines and serialises H0 results to memory
module nonce_batch_scheduler
    import sha_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_NONCES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [15:0]               output_addr,
    output logic                      done,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [32*NUM_CORES-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0]      core_done,
    input  logic [32*NUM_CORES-1:0]   core_h0,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [15:0]               mem_addr,
    output logic [31:0]               mem_write_data
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t                        state;
    state_t                        state_next;
    logic [8:0]                    nb;
    logic [8:0]                    nb_next;
    logic [15:0]                   base_addr;
    logic [NUM_CORES-1:0]          active_mask;
    logic [NUM_CORES-1:0]          mask_next;
    logic [NUM_CORES-1:0]          start_q;
    logic [NUM_CORES-1:0][31:0]    nonce_q;
    logic [NUM_CORES-1:0][31:0]    h0_buf;
    logic [IDX_W-1:0]              w;
    logic [IDX_W-1:0]              last_w;
    logic [9:0]                    remaining;
    logic                          load_batch;
    logic                          all_done;

    // Cores whose nonce (base + core index) still lies inside the sweep.
    function automatic logic [NUM_CORES-1:0] batch_mask(input logic [8:0] base);
        logic [NUM_CORES-1:0] m;
        for (int c = 0; c < NUM_CORES; c++) begin
            m[c] = (({1'b0, base} + 10'(c)) < 10'(NUM_NONCES));
        end
        return m;
    endfunction

    // Index of the last active core in the current batch and the all-finished condition.
    always_comb begin
        remaining = 10'(NUM_NONCES) - {1'b0, nb};
        last_w    = IDX_W'(NUM_CORES - 1);
        if (remaining < 10'(NUM_CORES)) begin
            last_w = IDX_W'(remaining - 10'd1);
        end
        all_done = ((core_done & active_mask) == active_mask);
    end

    // Next-state logic; load_batch marks the edge that enters DISPATCH.
    always_comb begin
        state_next = state;
        nb_next    = nb;
        load_batch = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nb_next    = 9'd0;
                    state_next = DISPATCH;
                    load_batch = 1'b1;
                end
            end
            DISPATCH: state_next = ARM;
            ARM:      state_next = WAIT;
            WAIT: begin
                if (all_done) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (w == last_w) begin
                    nb_next = nb + 9'(NUM_CORES);
                    if (nb_next < 9'(NUM_NONCES)) begin
                        state_next = DISPATCH;
                        load_batch = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        mask_next = batch_mask(nb_next);
    end

    // State, batch bookkeeping, engine start/nonce registers and the result buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            nb          <= 9'd0;
            base_addr   <= 16'd0;
            active_mask <= '0;
            start_q     <= '0;
            nonce_q     <= '0;
            h0_buf      <= '0;
            w           <= '0;
        end else begin
            state <= state_next;
            nb    <= nb_next;
            if (state == IDLE && start) begin
                base_addr <= output_addr;
            end
            start_q <= load_batch ? mask_next : '0;
            if (load_batch) begin
                active_mask <= mask_next;
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (mask_next[c]) begin
                        nonce_q[c] <= 32'(nb_next) + 32'(c);
                    end
                end
            end
            if (state == WAIT && all_done) begin
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (active_mask[c]) begin
                        h0_buf[c] <= core_h0[32*c +: 32];
                    end
                end
                w <= '0;
            end else if (state == WRITE) begin
                w <= w + 1'b1;
            end
        end
    end

    assign done           = (state == IDLE);
    assign core_start     = start_q;
    assign core_nonce     = nonce_q;
    assign mem_clk        = clk;
    assign mem_we         = (state == WRITE);
    assign mem_addr       = mem_we ? (base_addr + {7'd0, nb} + 16'(w)) : 16'd0;
    assign mem_write_data = mem_we ? h0_buf[w] : 32'd0;

endmodule

// File: tb/tb_nonce_batch_scheduler.sv
// tb/tb_nonce_batch_scheduler.sv - self-checking bench for nonce_batch_scheduler
module tb_nonce_batch_scheduler;

    localparam int NC = 4;
    localparam int NN = 14;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic [15:0]         output_addr = 16'd0;
    logic                done;
    logic [NC-1:0]       core_start;
    logic [32*NC-1:0]    core_nonce;
    logic [NC-1:0]       core_done;
    logic [32*NC-1:0]    core_h0;
    logic                mem_clk;
    logic                mem_we;
    logic [15:0]         mem_addr;
    logic [31:0]         mem_write_data;

    always #5 clk = ~clk;

    nonce_batch_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .output_addr(output_addr),
        .done(done),
        .core_start(core_start),
        .core_nonce(core_nonce),
        .core_done(core_done),
        .core_h0(core_h0),
        .mem_clk(mem_clk),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    wr_t  exp_e;
    int   lat[NC];
    int   exp_next[NC];
    int   starts[NC];
    int   writes_seen = 0;

    logic [NC-1:0]       eng_done = '1;
    logic [NC-1:0][31:0] eng_h0 = '0;
    logic [31:0]         eng_nonce[NC];
    int                  eng_cnt[NC];

    assign core_done = eng_done;
    assign core_h0   = eng_h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural engines: busy for lat[c] cycles after a start, then h0 = nonce ^ A5A5A5A5.
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (!reset_n) begin
                eng_done[c] <= 1'b1;
                eng_cnt[c]  <= 0;
            end else if (core_start[c]) begin
                eng_nonce[c] <= core_nonce[32*c +: 32];
                eng_cnt[c]   <= lat[c];
                eng_done[c]  <= 1'b0;
                eng_h0[c]    <= $urandom;
            end else if (eng_cnt[c] != 0) begin
                if (eng_cnt[c] == 1) begin
                    eng_done[c] <= 1'b1;
                    eng_h0[c]   <= eng_nonce[c] ^ 32'hA5A5A5A5;
                end
                eng_cnt[c] <= eng_cnt[c] - 1;
            end
        end
    end

    // Monitor: pops expected writes, checks engine start nonces.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                writes_seen++;
                check("engines_idle_at_write", 32'(&eng_done), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_write_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(exp_e.addr));
                    check("write_data", mem_write_data, exp_e.data);
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (core_start[c]) begin
                    starts[c]++;
                    check($sformatf("nonce_core%0d", c), core_nonce[32*c +: 32], 32'(exp_next[c]));
                    exp_next[c] += NC;
                end
            end
        end
    end

    task automatic begin_sweep(input logic [15:0] base, output int exp_cycles);
        int k;
        int l;
        wr_t e;
        exp_cycles = 0;
        for (int n = 0; n < NN; n++) begin
            e.addr = base + 16'(n);
            e.data = 32'(n) ^ 32'hA5A5A5A5;
            exp_q.push_back(e);
        end
        for (int b = 0; b < NN; b += NC) begin
            k = (NN - b < NC) ? (NN - b) : NC;
            l = 0;
            for (int c = 0; c < k; c++) begin
                if (lat[c] > l) l = lat[c];
            end
            exp_cycles += 2 + l + k;
        end
        for (int c = 0; c < NC; c++) begin
            exp_next[c] = c;
            starts[c]   = 0;
        end
        writes_seen = 0;
        @(posedge clk); #2;
        start = 1'b1;
        output_addr = base;
        @(posedge clk); #2;
        start = 1'b0;
        output_addr = 16'($urandom);
        check("done_low_after_start", 32'(done), 32'd0);
    endtask

    task automatic finish_sweep(input int exp_cycles, input bit poke);
        int cnt;
        int e;
        bit ok;
        cnt = 1;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #2;
            if (done) begin
                ok = 1'b1;
                break;
            end
            cnt++;
            if (poke) begin
                start = (cnt == 6);
                output_addr = 16'h5555;
            end
        end
        start = 1'b0;
        check("sweep_completed", 32'(ok), 32'd1);
        check("sweep_cycles", 32'(cnt), 32'(exp_cycles));
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < NC; c++) begin
            e = 0;
            for (int n = 0; n < NN; n++) begin
                if (n % NC == c) e++;
            end
            check($sformatf("start_count_core%0d", c), 32'(starts[c]), 32'(e));
        end
    endtask

    task automatic set_lat(input int l0, input int lr);
        lat[0] = l0;
        for (int c = 1; c < NC; c++) lat[c] = lr;
    endtask

    initial begin
        int s;
        set_lat(10, 10);
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 32'(done), 32'd1);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_core_start", 32'(core_start), 32'd0);
        check("reset_core_nonce_lo", core_nonce[31:0], 32'd0);
        check("reset_core_nonce_hi", core_nonce[32*NC-1 -: 32], 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_data", mem_write_data, 32'd0);
        #1 reset_n = 1'b1;

        begin_sweep(16'h0100, s);
        finish_sweep(s, 1'b0);

        set_lat(30, 5);
        begin_sweep(16'h0100, s);
        finish_sweep(s, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NC; c++) lat[c] = $urandom_range(1, 20);
            begin_sweep(16'($urandom), s);
            finish_sweep(s, 1'b0);
        end

        set_lat(10, 10);
        begin_sweep(16'hFFFE, s);
        finish_sweep(s, 1'b0);

        begin_sweep(16'h0200, s);
        finish_sweep(s, 1'b1);
        repeat (30) @(posedge clk);
        #2;
        check("no_second_sweep_done", 32'(done), 32'd1);
        check("no_second_sweep_writes", 32'(writes_seen), 32'(NN));

        begin_sweep(16'h0100, s);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (writes_seen >= 5) break;
        end
        check("we_before_reset", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_core_start", 32'(core_start), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int c = 0; c < NC; c++) lat[c] = $urandom_range(1, 20);
        begin_sweep(16'h0100, s);
        finish_sweep(s, 1'b0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
